// File: rtl/isa_pkg.sv
// Shared constants and types for the register-file write-back path.
package isa_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 2 ** ADDR_W;

    // Requester index; also the encoding of the arbiter's "granted last" pointer
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // One write-back payload
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two requesters, scoreboard control, and the register-file write port.
interface regfile_wb_arbiter_if;
    import isa_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_set_addr;
    logic              flush;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   pending;

    // Pipeline side: drives requests and scoreboard control
    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output sb_set, sb_set_addr, flush,
        input  a_ready, m_ready, rf_we, rf_waddr, rf_wdata, pending
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  sb_set, sb_set_addr, flush,
        output a_ready, m_ready, rf_we, rf_waddr, rf_wdata, pending
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers who was granted last.
module rr_arb2
    import isa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    req_e last_q, last_d;

    // Lone requester wins; on conflict the one not granted last wins
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when a grant actually transfers
    always_comb begin
        last_d = last_q;
        if (adv && (gnt != 2'b00)) begin
            last_d = gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

    // Reset as if MEM was granted last so ALU wins the first conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= REQ_MEM;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load write-back,
// and keeps a per-register pending scoreboard for RAW stalls.
module regfile_wb_arbiter
    import isa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    logic [1:0]        req, gnt;
    logic              xfer;
    wb_req_t           sel;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   pending_q, pending_d;

    // Flush and reset suppress every request so neither ready can rise
    assign req = {bus.m_valid, bus.a_valid} & {2{~bus.flush & rst_n}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (xfer),
        .gnt   (gnt)
    );

    assign bus.a_ready = gnt[REQ_ALU];
    assign bus.m_ready = gnt[REQ_MEM];
    assign xfer        = |gnt;

    // Payload of whichever requester is granted
    always_comb begin
        sel = '{addr: bus.a_addr, data: bus.a_data};
        if (gnt[REQ_MEM]) sel = '{addr: bus.m_addr, data: bus.m_data};
    end

    // Write port capture and scoreboard update; set beats clear, flush beats both
    always_comb begin
        rf_we_d    = xfer;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pending_d  = pending_q;
        if (xfer) begin
            rf_waddr_d          = sel.addr;
            rf_wdata_d          = sel.data;
            pending_d[sel.addr] = 1'b0;
        end
        if (bus.sb_set) pending_d[bus.sb_set_addr] = 1'b1;
        if (bus.flush)  pending_d = '0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pending  = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a behavioural model predicts each
// accepted write and the pending vector; a negedge monitor compares.
module tb_regfile_wb_arbiter;
    import isa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t             exp_q[$];
    logic [NREG-1:0] m_pend = '0;
    bit              m_last_mem = 1'b1;   // true: the load side was served last

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = nobody, 1 = ALU, 2 = load
    function automatic int model_grant();
        if (!rst_n || bus.flush) return 0;
        if (bus.a_valid && bus.m_valid) return m_last_mem ? 1 : 2;
        if (bus.a_valid) return 1;
        if (bus.m_valid) return 2;
        return 0;
    endfunction

    // Reference model: decides acceptance and pending at each edge
    always @(posedge clk) begin : model
        int g;
        if (rst_n) begin
            g = model_grant();
            if (g == 1) begin
                exp_q.push_back('{bus.a_addr, bus.a_data});
                m_pend[bus.a_addr] = 1'b0;
                m_last_mem = 1'b0;
            end else if (g == 2) begin
                exp_q.push_back('{bus.m_addr, bus.m_data});
                m_pend[bus.m_addr] = 1'b0;
                m_last_mem = 1'b1;
            end
            if (bus.sb_set) m_pend[bus.sb_set_addr] = 1'b1;
            if (bus.flush)  m_pend = '0;
        end
    end

    // Monitor: readies, write port and pending against the model
    always @(negedge clk) begin : monitor
        int  g;
        wr_t e;
        if (rst_n) begin
            g = model_grant();
            chk("a_ready", 32'(bus.a_ready), 32'(g == 1));
            chk("m_ready", 32'(bus.m_ready), 32'(g == 2));
            chk("rf_we", 32'(bus.rf_we), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (bus.rf_we) begin
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
                    chk("rf_wdata", 32'(bus.rf_wdata), 32'(e.data));
                end
            end
            chk("pending", 32'(bus.pending), 32'(m_pend));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
        bus.sb_set = 1'b0;  bus.sb_set_addr = '0;
        bus.flush = 1'b0;
    endtask

    // Observe handshakes, then advance to just after the next edge
    task automatic step(output bit ga, output bit gm);
        @(negedge clk);
        ga = bus.a_valid && bus.a_ready;
        gm = bus.m_valid && bus.m_ready;
        cyc();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rf_we"},    32'(bus.rf_we), 32'd0);
        chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
        chk({tag, "_rf_wdata"}, 32'(bus.rf_wdata), 32'd0);
        chk({tag, "_pending"},  32'(bus.pending), 32'd0);
    endtask

    // Asynchronous reset mid-cycle, then release just after an edge
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        exp_q.delete();
        m_pend = '0;
        m_last_mem = 1'b1;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        bit ga, gm;
        idle_inputs();
        // Reset: readies stay low even with a request presented
        #3;
        bus.a_valid = 1'b1; bus.m_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
        check_zero_outputs("rst");
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();

        // Contention, each side drops after its accept: A then M
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 16'hAAAA;
        bus.m_valid = 1'b1; bus.m_addr = 4'd6; bus.m_data = 16'h5555;
        @(negedge clk);
        chk("cont_a_first", 32'(bus.a_ready), 32'd1);
        chk("cont_m_wait", 32'(bus.m_ready), 32'd0);
        cyc(); bus.a_valid = 1'b0;
        @(negedge clk);
        chk("cont_m_second", 32'(bus.m_ready), 32'd1);
        chk("cont_wr5", 32'(bus.rf_waddr), 32'd5);
        cyc(); bus.m_valid = 1'b0;
        @(negedge clk);
        chk("cont_wr6_we", 32'(bus.rf_we), 32'd1);
        chk("cont_wr6", 32'(bus.rf_waddr), 32'd6);
        chk("cont_wr6_data", 32'(bus.rf_wdata), 32'h5555);
        cyc();

        // Single ALU write
        bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 16'h1234;
        @(negedge clk);
        chk("single_a_ready", 32'(bus.a_ready), 32'd1);
        cyc(); bus.a_valid = 1'b0;
        @(negedge clk);
        chk("single_we", 32'(bus.rf_we), 32'd1);
        chk("single_addr", 32'(bus.rf_waddr), 32'd3);
        chk("single_data", 32'(bus.rf_wdata), 32'h1234);
        cyc();
        @(negedge clk);
        chk("single_we_drop", 32'(bus.rf_we), 32'd0);
        cyc();

        // Continuous contention: ALU served last, so M, A, M, A ...
        bus.a_valid = 1'b1; bus.m_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_a", 32'(bus.a_ready), 32'(i % 2 == 1));
            chk("alt_m", 32'(bus.m_ready), 32'(i % 2 == 0));
            ga = bus.a_ready; gm = bus.m_ready;
            cyc();
            if (ga) begin bus.a_addr = ADDR_W'($urandom); bus.a_data = DATA_W'($urandom); end
            if (gm) begin bus.m_addr = ADDR_W'($urandom); bus.m_data = DATA_W'($urandom); end
        end
        for (int i = 0; i < 4 && (bus.a_valid || bus.m_valid); i++) begin
            step(ga, gm);
            if (ga) bus.a_valid = 1'b0;
            if (gm) bus.m_valid = 1'b0;
        end
        cyc();

        // Scoreboard: set, then cleared by a load transfer
        bus.sb_set = 1'b1; bus.sb_set_addr = 4'd7;
        cyc(); bus.sb_set = 1'b0;
        cyc();
        @(negedge clk);
        chk("sb_set7", 32'(bus.pending[7]), 32'd1);
        cyc();
        bus.m_valid = 1'b1; bus.m_addr = 4'd7; bus.m_data = 16'hBEEF;
        cyc(); bus.m_valid = 1'b0;
        @(negedge clk);
        chk("sb_clr7", 32'(bus.pending[7]), 32'd0);
        cyc();
        // Set and clear of the same register together: set wins
        bus.m_valid = 1'b1; bus.m_addr = 4'd7; bus.m_data = 16'h0007;
        bus.sb_set = 1'b1; bus.sb_set_addr = 4'd7;
        cyc(); bus.m_valid = 1'b0; bus.sb_set = 1'b0;
        @(negedge clk);
        chk("sb_set_wins", 32'(bus.pending[7]), 32'd1);
        cyc();
        // Set and clear of different registers: both apply
        bus.m_valid = 1'b1; bus.m_addr = 4'd7; bus.m_data = 16'h0077;
        bus.sb_set = 1'b1; bus.sb_set_addr = 4'd8;
        cyc(); bus.m_valid = 1'b0; bus.sb_set = 1'b0;
        @(negedge clk);
        chk("sb_both", 32'(bus.pending[8:7]), 32'b10);
        cyc();

        // Flush: build pending = 00F0 then flush with a request and a set present
        bus.a_valid = 1'b1; bus.a_addr = 4'd8; bus.a_data = 16'h0808;
        cyc(); bus.a_valid = 1'b0;
        for (int r = 4; r < 8; r++) begin
            bus.sb_set = 1'b1; bus.sb_set_addr = ADDR_W'(r);
            cyc();
        end
        bus.sb_set = 1'b0;
        @(negedge clk);
        chk("pre_flush_pend", 32'(bus.pending), 32'h00F0);
        cyc();
        bus.a_valid = 1'b1; bus.a_addr = 4'd2; bus.a_data = 16'h0F0F;
        bus.flush = 1'b1; bus.sb_set = 1'b1; bus.sb_set_addr = 4'd1;
        @(negedge clk);
        chk("flush_no_ready", 32'(bus.a_ready), 32'd0);
        cyc(); bus.flush = 1'b0; bus.sb_set = 1'b0;
        @(negedge clk);
        chk("flush_pend", 32'(bus.pending), 32'd0);
        chk("flush_no_we", 32'(bus.rf_we), 32'd0);
        chk("post_flush_ready", 32'(bus.a_ready), 32'd1);
        cyc(); bus.a_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_addr", 32'(bus.rf_waddr), 32'd2);
        cyc();

        // Back-to-back loads, one write per cycle
        for (int i = 0; i < 8; i++) begin
            bus.m_valid = 1'b1; bus.m_addr = ADDR_W'(i); bus.m_data = DATA_W'(i * 16'h0101);
            @(negedge clk);
            chk("b2b_ready", 32'(bus.m_ready), 32'd1);
            if (i > 0) chk("b2b_addr", 32'(bus.rf_waddr), 32'(i - 1));
            cyc();
        end
        bus.m_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_data", 32'(bus.rf_wdata), 32'h0707);
        cyc();

        // Reset while a write is on the port
        bus.a_valid = 1'b1; bus.a_addr = 4'd9; bus.a_data = 16'hCAFE;
        cyc(); bus.a_valid = 1'b0;
        #2;
        chk("mid_write_we", 32'(bus.rf_we), 32'd1);
        do_reset();
        cyc();

        // Randomized traffic with holds, flushes and scoreboard sets
        for (int n = 0; n < 3000; n++) begin
            step(ga, gm);
            if (n == 1500) begin
                do_reset();
            end else begin
                if (!bus.a_valid || ga) begin
                    bus.a_valid = ($urandom_range(0, 3) != 0);
                    bus.a_addr  = ADDR_W'($urandom);
                    bus.a_data  = DATA_W'($urandom);
                end
                if (!bus.m_valid || gm) begin
                    bus.m_valid = ($urandom_range(0, 3) != 0);
                    bus.m_addr  = ADDR_W'($urandom);
                    bus.m_data  = DATA_W'($urandom);
                end
                bus.flush       = ($urandom_range(0, 15) == 0);
                bus.sb_set      = ($urandom_range(0, 1) == 1);
                bus.sb_set_addr = ADDR_W'($urandom);
            end
        end
        // Let any held request drain before stopping
        bus.flush = 1'b0; bus.sb_set = 1'b0;
        for (int i = 0; i < 4 && (bus.a_valid || bus.m_valid); i++) begin
            step(ga, gm);
            if (ga) bus.a_valid = 1'b0;
            if (gm) bus.m_valid = 1'b0;
        end
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: ALU result (A) and memory load (M).
- Round-robin arbitration; valid/ready handshake per requester; registered write-port outputs.
- Per-register pending scoreboard so the issue stage can stall on read-after-write hazards.
- Sits between execute/memory stages and the 16x16 register file write port (WriteData, RegWrite, destination index).

Parameters:
- DATA_W, 16, write data width
- ADDR_W, 4, register index width
- NREG, 16, number of registers (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  ALU write-back request
- a_ready  output  1  ALU request accepted this cycle
- a_addr  input  ADDR_W  ALU destination register
- a_data  input  DATA_W  ALU result
- m_valid  input  1  load write-back request
- m_ready  output  1  load request accepted this cycle
- m_addr  input  ADDR_W  load destination register
- m_data  input  DATA_W  load data
- sb_set  input  1  issue stage marks a destination as pending
- sb_set_addr  input  ADDR_W  register to mark pending
- flush  input  1  pipeline flush
- rf_we  output  1  register-file write enable (RegWrite)
- rf_waddr  output  ADDR_W  write index
- rf_wdata  output  DATA_W  write data
- pending  output  NREG  bit i = write to register i outstanding

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0.
  - Priority pointer set so A wins the first conflict.
  - a_ready and m_ready are combinational and are 0 while in reset.
- Handshake:
  - Transfer occurs when valid && ready on a rising edge.
  - A requester must hold valid, addr and data stable until accepted; the arbiter never drops a presented request except on flush.
- Arbitration (combinational grant, at most one ready per cycle):
  - only one valid: that requester is granted.
  - both valid: the requester not granted last is granted.
  - Pointer updates only on an actual transfer; no transfer leaves it unchanged.
  - Result: no requester waits more than 1 cycle under continuous contention.
- Write port:
  - The accepted request is registered; rf_we=1 with rf_waddr/rf_wdata exactly 1 cycle after the transfer edge.
  - rf_we=0 in any cycle following no transfer.
  - Full throughput: one write per cycle, back-to-back.
- Scoreboard:
  - sb_set sets pending[sb_set_addr] at the clock edge.
  - A transfer clears pending[addr] at the transfer edge, so the bit is already low in the cycle rf_we is high.
  - Simultaneous set and clear of the same register: set wins (newer producer outstanding).
  - Set and clear of different registers in one cycle: both take effect.
  - Clearing a bit that is already 0 is legal and has no effect.
- Flush:
  - a_ready=m_ready=0 that cycle (no transfer).
  - pending cleared to 0; a simultaneous sb_set is ignored.
  - Pointer is kept.
  - A write already registered from the previous cycle still completes (rf_we stays as registered).
- Register 0 is an ordinary writable register; no special casing.
- No arithmetic; all address/data paths pass through at full width.

Decomposition:
- Shared package isa_pkg: DATA_W, ADDR_W, NREG constants; requester index encoding (REQ_ALU=0, REQ_MEM=1).
- One natural sub-module: rr_arb2, a two-input round-robin arbiter with a pointer register, clk/rst_n, and an advance-on-transfer input.
- Scoreboard and write-port register stay in the top module.

Test Plan:
- Reset then idle: rst_n low mid-write, with rf_we=1 pending -> all outputs 0 immediately (async); after release, a_ready=m_ready=0 while valids are low.
- Single ALU write: a_valid=1, a_addr=3, a_data=16'h1234 -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234; following cycle rf_we=0.
- Contention: a_valid=m_valid=1 held 4 cycles, A:(5,16'hAAAA), M:(6,16'h5555), each requester deasserting after its own accept -> grants A, M; rf writes reg5 then reg6 in consecutive cycles. With both held continuously and fresh payloads each cycle -> grants alternate A, M, A, M.
- Scoreboard: sb_set on reg7; two cycles later an M transfer to reg7 -> pending[7]=1 then 0 at the transfer edge. In the same cycle as that transfer, sb_set reg7 -> pending[7] remains 1.
- Flush: pending=16'h00F0, a_valid=1, flush=1 -> a_ready=0, pending=0 next cycle, no rf_we; flush=0 next cycle -> A accepted normally.
- Back-to-back throughput: m_valid held 8 cycles with addresses 0..7 and data = addr*16'h0101 -> 8 consecutive rf_we cycles with matching addr/data, no bubbles.
